seg_scan_sched: RTL
===================

# seg_scan_sched

Scan scheduler for the multiplexed seven-segment display. It walks NUM_DIGITS digits at a fixed prescaled rate and decodes each hex nibble to segments. It packs the segments and the digit select into the 16-bit word the shift-register output stage serialises, and hands each word off with a valid/ready plus done handshake. It sits between the application's value register and the shift-register driver, and it owns display refresh, tear-free value updates and per-digit blanking.

## Interface
Parameters:
- NUM_DIGITS, 3, digits scanned per frame (2..4)
- TICK_BITS, 6, prescaler width; one scan tick every 2^TICK_BITS cycles

Ports:
- CLK  in  1  system clock (16 MHz on board)
- RST  in  1  synchronous, active-high reset
- i_value  in  4*NUM_DIGITS  hex nibbles; digit k = i_value[4k +: 4]
- i_blank  in  NUM_DIGITS  per-digit blank request; bit k forces segments of digit k to 0
- i_load  in  1  capture i_value/i_blank into the shadow register
- o_sr_data  out  16  {6'b0, digit_sel[1:0], seg[7:0]}
- o_sr_valid  out  1  o_sr_data is valid for the shift-register stage
- i_sr_ready  in  1  shift-register stage accepts the word this cycle
- i_sr_done  in  1  one-cycle pulse when the accepted word has been latched to the outputs
- o_frame_done  out  1  one-cycle pulse after the last digit of a frame completes
- o_overrun  out  1  sticky; a tick arrived while the scheduler was not IDLE

## Operation
- Prescaler: TICK_BITS-bit up-counter that wraps. tick = (count == all ones).
- Shadow/active buffers:
  - i_load writes the shadow register.
  - The shadow is copied to the active register only when a frame starts, i.e. on a tick accepted with digit_idx == 0. This prevents tearing.
  - i_load in the same cycle as the copy: the new i_value is written to the shadow, and the old shadow is copied to active.
- Segment encoding: seg[6:0] = g..a, active high; seg[7] (dp) is always 0.
  - Hex values 0-F map to 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
  - Blanked digit: seg = 00.
- FSM states:
  - IDLE: on tick → LOAD.
  - LOAD: register o_sr_data for digit_idx → SEND.
  - SEND: o_sr_valid = 1. When i_sr_ready is high → WAIT.
  - WAIT: on i_sr_done → IDLE. Advance digit_idx: it wraps from NUM_DIGITS-1 to 0, and o_frame_done pulses in that same cycle.
- The word is registered in LOAD and held stable for the whole of SEND.
- Tick outside IDLE: the tick is dropped (not queued), o_overrun is set, and the FSM is unaffected. o_overrun clears only on RST.
- i_sr_done outside WAIT is ignored.
- i_sr_ready outside SEND is ignored.

## Timing
- Reset values:
  - o_sr_data = 0, o_sr_valid = 0, o_frame_done = 0, o_overrun = 0.
  - state = IDLE, digit_idx = 0, prescaler = 0, shadow and active registers = 0.
- RST overrides everything in the same edge. It aborts any transfer mid-operation, so o_sr_valid drops the cycle after RST is sampled.
- First tick after RST deassertion: prescaler reaches all ones 2^TICK_BITS-1 cycles later.
- Tick in cycle t (IDLE) → LOAD at t+1 → o_sr_valid = 1 from t+2.
- Handshake: transfer happens when o_sr_valid & i_sr_ready are both high. o_sr_valid drops the next cycle.
- i_sr_done at cycle d → IDLE, new digit_idx and o_frame_done (if wrapping) all take effect at d+1.
- Minimum handling per digit: 3 cycles plus the shift-register latency. For TICK_BITS=6 the shift-register round trip must complete within 61 cycles, otherwise overrun occurs.
- Copy to active happens at the frame-starting tick edge, so LOAD of digit 0 already uses the new value.

## Test plan
- Reset and first tick, TICK_BITS=6, i_sr_ready tied 1, i_sr_done 4 cycles after acceptance:
  - o_sr_valid first rises exactly 65 cycles after RST deassertion.
  - Expected o_sr_data = 0x003F (digit 0, value 0).
- Value 0x9A5 loaded, full frame:
  - Successive words are 0x006D, 0x0177, 0x026F.
  - o_frame_done pulses once, one cycle after the third i_sr_done.
  - Fourth word is 0x006D (digit_idx wraps to 0).
- Blank and tear-free update:
  - Load 0x123 with i_blank=3'b010 mid-frame, during digit 1.
  - The remaining digits of the current frame still show old values.
  - The next frame sends 0x004F, 0x0100, 0x0206.
- Backpressure: hold i_sr_ready low for 20 cycles in SEND.
  - o_sr_valid stays 1 and o_sr_data stays stable throughout.
  - Transfer occurs on the first cycle ready is high.
  - A tick arriving during that time sets o_overrun; digit order is unchanged.
- Spurious handshake: i_sr_done pulsed in IDLE and i_sr_ready high in WAIT.
  - No state change and no digit advance.
- Reset mid-transfer: assert RST in SEND with digit_idx=2.
  - Next cycle: o_sr_valid=0, o_overrun=0.
  - The next word sent is for digit 0 with value 0 (0x003F).

Source files
------------

// File: rtl/seg_scan_sched.sv
// Seven-segment scan scheduler: prescaled digit walk, hex decode and a valid/ready/done
// hand-off of {6'b0, digit_sel, seg} words to the shift-register output stage.
module seg_scan_sched #(
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned TICK_BITS  = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [4*NUM_DIGITS-1:0]   i_value,
  input  logic [NUM_DIGITS-1:0]     i_blank,
  input  logic                      i_load,
  output logic [15:0]               o_sr_data,
  output logic                      o_sr_valid,
  input  logic                      i_sr_ready,
  input  logic                      i_sr_done,
  output logic                      o_frame_done,
  output logic                      o_overrun
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StSend = 2'd2;
  localparam logic [1:0] StWait = 2'd3;

  localparam logic [1:0]           LastIdx  = 2'(NUM_DIGITS - 1);
  localparam logic [TICK_BITS-1:0] PrescOne = TICK_BITS'(1);

  logic [TICK_BITS-1:0]    presc_q, presc_d;
  logic [1:0]              state_q, state_d;
  logic [1:0]              idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
  logic [4*NUM_DIGITS-1:0] active_val_q, active_val_d;
  logic [NUM_DIGITS-1:0]   active_blank_q, active_blank_d;
  logic [15:0]             data_q, data_d;
  logic                    frame_done_q, frame_done_d;
  logic                    overrun_q, overrun_d;

  logic       tick;
  logic [3:0] nib;
  logic       blank;
  logic [7:0] seg;

  function automatic logic [6:0] hex2seg(input logic [3:0] n);
    case (n)
      4'h0: hex2seg = 7'h3F;
      4'h1: hex2seg = 7'h06;
      4'h2: hex2seg = 7'h5B;
      4'h3: hex2seg = 7'h4F;
      4'h4: hex2seg = 7'h66;
      4'h5: hex2seg = 7'h6D;
      4'h6: hex2seg = 7'h7D;
      4'h7: hex2seg = 7'h07;
      4'h8: hex2seg = 7'h7F;
      4'h9: hex2seg = 7'h6F;
      4'hA: hex2seg = 7'h77;
      4'hB: hex2seg = 7'h7C;
      4'hC: hex2seg = 7'h39;
      4'hD: hex2seg = 7'h5E;
      4'hE: hex2seg = 7'h79;
      default: hex2seg = 7'h71;
    endcase
  endfunction

  assign tick = &presc_q;

  always_comb begin
    nib   = 4'h0;
    blank = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx_q == 2'(k)) begin
        nib   = active_val_q[4*k +: 4];
        blank = active_blank_q[k];
      end
    end
    seg = blank ? 8'h00 : {1'b0, hex2seg(nib)};
  end

  always_comb begin
    presc_d        = presc_q + PrescOne;
    state_d        = state_q;
    idx_d          = idx_q;
    shadow_val_d   = shadow_val_q;
    shadow_blank_d = shadow_blank_q;
    active_val_d   = active_val_q;
    active_blank_d = active_blank_q;
    data_d         = data_q;
    frame_done_d   = 1'b0;
    overrun_d      = overrun_q;

    if (i_load) begin
      shadow_val_d   = i_value;
      shadow_blank_d = i_blank;
    end

    case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StLoad;
          // Frame boundary: latch the pre-load shadow so a frame never mixes values.
          if (idx_q == 2'd0) begin
            active_val_d   = shadow_val_q;
            active_blank_d = shadow_blank_q;
          end
        end
      end
      StLoad: begin
        data_d  = {6'b0, idx_q, seg};
        state_d = StSend;
      end
      StSend: begin
        if (i_sr_ready) state_d = StWait;
      end
      default: begin
        if (i_sr_done) begin
          state_d = StIdle;
          if (idx_q == LastIdx) begin
            idx_d        = 2'd0;
            frame_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
    endcase

    if (tick && (state_q != StIdle)) overrun_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q        <= '0;
      state_q        <= StIdle;
      idx_q          <= 2'd0;
      shadow_val_q   <= '0;
      shadow_blank_q <= '0;
      active_val_q   <= '0;
      active_blank_q <= '0;
      data_q         <= 16'h0000;
      frame_done_q   <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      state_q        <= state_d;
      idx_q          <= idx_d;
      shadow_val_q   <= shadow_val_d;
      shadow_blank_q <= shadow_blank_d;
      active_val_q   <= active_val_d;
      active_blank_q <= active_blank_d;
      data_q         <= data_d;
      frame_done_q   <= frame_done_d;
      overrun_q      <= overrun_d;
    end
  end

  assign o_sr_data    = data_q;
  assign o_sr_valid   = (state_q == StSend);
  assign o_frame_done = frame_done_q;
  assign o_overrun    = overrun_q;

endmodule
